// File: rtl/obb_pkg.sv
// Shared types and defaults for the point-stream source.
package obb_pkg;

    localparam int NPTS_DFLT = 16;
    localparam int DW_DFLT   = 10;
    localparam int IW_DFLT   = $clog2(NPTS_DFLT);

    // Controller states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } state_e;

    // One stored point, x in the most significant field
    typedef struct packed {
        logic signed [DW_DFLT-1:0] x;
        logic signed [DW_DFLT-1:0] y;
        logic signed [DW_DFLT-1:0] z;
    } point_t;

endpackage

// File: rtl/obb_point_buf.sv
// Point buffer: NPTS entries of W bits, one write port and one registered
// read port. Storage is deliberately not reset; only the read register is.
module obb_point_buf
    import obb_pkg::*;
#(
    parameter int NPTS = NPTS_DFLT,
    parameter int W    = 3 * DW_DFLT,
    localparam int IW  = $clog2(NPTS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [IW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    input  logic [IW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem_q [NPTS];
    logic [W-1:0] rd_data_q;
    logic [W-1:0] rd_data_d;

    // Storage write port
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read mux; the register holds its value unless a read is requested
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem_q[rd_addr_i];
        end
    end

    // Read register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/obb_point_streamer.sv
// Source end of the point stream: owns the point buffer, replays it one
// point per accepted beat on start, then waits for the consumer to finish.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | buffer writable; start accepted only when all slots loaded
// STREAM   | presenting point ptr; advance on out_valid & out_ready
// WAIT_ACK | last point taken; waiting for cons_done
// DONE     | one-cycle done pulse, buffer writable, start ignored
module obb_point_streamer
    import obb_pkg::*;
#(
    parameter int NPTS = NPTS_DFLT,
    parameter int DW   = DW_DFLT,
    localparam int IW  = $clog2(NPTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [IW-1:0]        wr_addr_i,
    input  logic signed [DW-1:0] wr_x_i,
    input  logic signed [DW-1:0] wr_y_i,
    input  logic signed [DW-1:0] wr_z_i,
    input  logic                 start_i,
    input  logic                 out_ready_i,
    input  logic                 cons_done_i,
    output logic                 out_valid_o,
    output logic signed [DW-1:0] out_x_o,
    output logic signed [DW-1:0] out_y_o,
    output logic signed [DW-1:0] out_z_o,
    output logic [IW-1:0]        out_idx_o,
    output logic                 out_last_o,
    output logic                 busy_o,
    output logic                 loaded_o,
    output logic                 done_o,
    output logic                 err_o
);

    // ptr carries one extra bit so it can step past the final index
    localparam logic [IW:0] PTR_LAST = (IW + 1)'(NPTS - 1);

    state_e            state_q;
    state_e            state_d;
    logic [IW:0]       ptr_q;
    logic [IW:0]       ptr_d;
    logic [NPTS-1:0]   mask_q;
    logic [NPTS-1:0]   mask_d;
    logic              loaded_q;
    logic              err_q;
    logic              err_d;

    logic              wr_ok;
    logic              start_ok;
    logic              xfer;
    logic              at_last;
    logic              rd_en;
    logic [IW-1:0]     rd_addr;
    logic [3*DW-1:0]   wr_data;
    logic [3*DW-1:0]   rd_data;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_ok)           state_d = STREAM;
            STREAM:   if (xfer && at_last)    state_d = WAIT_ACK;
            WAIT_ACK: if (cons_done_i)        state_d = DONE;
            DONE:                             state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        out_valid_o = (state_q == STREAM);
        busy_o      = (state_q != IDLE);
        done_o      = (state_q == DONE);
        out_last_o  = (state_q == STREAM) && at_last;
    end

    // Handshake, pointer, write-enable and load-mask steering
    always_comb begin
        at_last  = (ptr_q == PTR_LAST);
        wr_ok    = wr_en_i && ((state_q == IDLE) || (state_q == DONE));
        start_ok = (state_q == IDLE) && start_i && loaded_q;
        err_d    = (state_q == IDLE) && start_i && !loaded_q;
        xfer     = (state_q == STREAM) && out_ready_i;

        mask_d = mask_q;
        if (wr_ok) begin
            mask_d[wr_addr_i] = 1'b1;
        end

        ptr_d = ptr_q;
        if (start_ok) begin
            ptr_d = '0;
        end else if (xfer) begin
            ptr_d = ptr_q + 1'b1;
        end

        // Fetch the point that will be presented after this edge; no fetch
        // after the last beat so the data register simply holds.
        rd_en   = start_ok || (xfer && !at_last);
        rd_addr = ptr_d[IW-1:0];
    end

    // Pointer, mask, loaded flag and error pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            mask_q   <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            mask_q   <= mask_d;
            loaded_q <= &mask_d;
            err_q    <= err_d;
        end
    end

    assign wr_data = {wr_x_i, wr_y_i, wr_z_i};

    obb_point_buf #(
        .NPTS (NPTS),
        .W    (3 * DW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_ok),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign out_x_o   = rd_data[3*DW-1 -: DW];
    assign out_y_o   = rd_data[2*DW-1 -: DW];
    assign out_z_o   = rd_data[DW-1   -: DW];
    assign out_idx_o = ptr_q[IW-1:0];
    assign loaded_o  = loaded_q;
    assign err_o     = err_q;

endmodule
